t01_ai_move_sequencer: RTL
==========================

// Module: t01_ai_move_sequencer
// PURPOSE
// - Sits between the AI inference pipeline (best_move_id/done_ai) and the tetris game FSM.
// - Turns one recommended move ID into a paced train of one-cycle rotate/left/right/drop pulses,
//   the same pulses the debounced buttons drive, so the FSM accepts AI moves as player input.
// - Uses the live piece column fed back from the FSM for closed-loop shifting.
// - Aborts cleanly when the piece locks or a new piece spawns.
// PARAMETERS
// - GAP_CYCLES   default 4     idle cycles after each pulse; must exceed FSM input sampling latency
// - MAX_TRIES    default 12    shift pulses allowed before giving up (blocked by wall/stack)
// - NUM_COLS     default 10    board width; move_id = rot*NUM_COLS + col
// - AUTO_DROP    default 1     1: issue drop pulse after placement; 0: end in DONE without drop
// PORTS
// - clk           in   1  25 MHz system clock
// - reset_n       in   1  asynchronous, active-low reset
// - enable_i      in   1  AI mode enable; low forces IDLE and suppresses all pulses
// - done_ai_i     in   1  AI inference complete (level); its rising edge starts a sequence
// - move_id_i     in   6  recommended move: rotation = id / NUM_COLS, target col = id % NUM_COLS
// - piece_col_i   in   4  current left column of active piece bounding box (0..NUM_COLS-1)
// - new_piece_i   in   1  one-cycle pulse from FSM when a piece spawns/locks; aborts sequence
// - rotate_r_o    out  1  one-cycle rotate-right request
// - left_o        out  1  one-cycle shift-left request
// - right_o       out  1  one-cycle shift-right request
// - drop_o        out  1  one-cycle hard/speed drop request
// - busy_o        out  1  high while not IDLE/DONE
// - done_o        out  1  one-cycle pulse when sequence finishes (normal or give-up)
// - err_o         out  1  sticky: invalid move_id seen or MAX_TRIES exhausted; cleared at next start
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, done_ai edge register 0.
// - Start: state IDLE, enable_i=1, done_ai_i rises (registered edge detect) -> LATCH next cycle.
//   done_ai_i held high does not retrigger. An edge seen outside IDLE is ignored.
// - LATCH (1 cycle): decode move_id_i with a compare ladder, no divider: rot_cnt 0..3,
//   tgt_col 0..NUM_COLS-1. If move_id_i >= 4*NUM_COLS: set err_o, go to DONE, emit no pulses.
//   Otherwise clear err_o, try_cnt=0 -> ROTATE (rot_cnt>0) or SHIFT (rot_cnt=0).
// - ROTATE: rotate_r_o=1 one cycle, rot_cnt-- -> ROT_GAP.
// - ROT_GAP: waits GAP_CYCLES, then -> ROTATE if rot_cnt>0, else SHIFT.
// - SHIFT: compares piece_col_i with tgt_col.
//   equal -> DROP (AUTO_DROP=1) or DONE.
//   piece_col_i > tgt_col -> left_o pulse; less -> right_o pulse; try_cnt++ -> SHIFT_GAP.
//   try_cnt == MAX_TRIES before pulsing -> set err_o, -> DROP/DONE as above.
// - SHIFT_GAP: waits GAP_CYCLES, then re-evaluates in SHIFT. Column is sampled only in SHIFT.
// - DROP: drop_o=1 one cycle -> DONE.
// - DONE: done_o=1 one cycle -> IDLE.
// - At most one of rotate_r_o/left_o/right_o/drop_o is high in any cycle.
//   Every pulse is followed by >= GAP_CYCLES low cycles.
// - Abort, highest priority: new_piece_i=1 or enable_i=0 in any non-IDLE state -> IDLE next cycle.
//   No pulse, no done_o. A pulse in the same cycle as the abort is suppressed.
//   new_piece_i and a done_ai_i edge in the same IDLE cycle: the start wins; new_piece_i has no IDLE effect.
// - Gap counter width: $clog2(GAP_CYCLES+1). try_cnt width: $clog2(MAX_TRIES+1). Counters saturate, never wrap.
// - Latency: done_ai_i edge -> first pulse = 3 cycles (edge reg, LATCH, ROTATE/SHIFT).
//   Full rot=3, 4-shift move with drop = 3 + 7*(1+GAP_CYCLES) + 1 + 1 cycles.
// - reset_n low mid-sequence: immediate return to reset values; no residual pulse after release.
// STRUCTURE
// - Shared package t01_ai_pkg holds:
//   seq_state_t enum (IDLE, LATCH, ROTATE, ROT_GAP, SHIFT, SHIFT_GAP, DROP, DONE),
//   NUM_COLS, NUM_ROTS=4, MOVE_ID_W=6, COL_W=4.
// - One sub-module: t01_move_decode (combinational move_id -> {valid, rot, col}),
//   reusable by the AI top for move enumeration.
// - Everything else is one always_ff next-state/output-register block plus a comb next-state block.
//   All outputs are registered.
// TESTING
// - move_id=23 (rot 2, col 3), piece_col=5 fixed by model that tracks pulses
//   -> 2 rotate_r_o, 2 left_o, 1 drop_o, done_o; pulses spaced by 4 idle cycles; err_o=0.
// - move_id=7, piece_col stuck at 4 (blocked) -> exactly 12 right_o pulses, err_o=1, drop_o, done_o.
// - move_id=45 -> no action pulses, err_o=1, done_o 2 cycles after LATCH entry;
//   next valid start clears err_o.
// - new_piece_i during the second rotate gap of move_id=30 -> no further pulses,
//   no done_o, busy_o low next cycle.
// - done_ai_i held high 100 cycles -> exactly one sequence; enable_i=0 mid-SHIFT -> IDLE,
//   no pulses while low.
// - reset_n asserted mid-ROT_GAP -> all outputs 0 asynchronously;
//   after release, no pulse until a new done_ai_i rising edge.

Source files
------------

// File: rtl/t01_ai_pkg.sv
// Shared types and board constants for the AI move sequencer and its move decoder.
package t01_ai_pkg;

    localparam int unsigned NUM_COLS  = 10;
    localparam int unsigned NUM_ROTS  = 4;
    localparam int unsigned MOVE_ID_W = 6;
    localparam int unsigned COL_W     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StRotate,
        StRotGap,
        StShift,
        StShiftGap,
        StDrop,
        StDone
    } seq_state_t;

endpackage

// File: rtl/t01_move_decode.sv
// Combinational move-ID decoder: move_id = rot*NUM_COLS + col, split with a compare ladder.
module t01_move_decode #(
    parameter int unsigned NUM_COLS = t01_ai_pkg::NUM_COLS
) (
    input  logic [t01_ai_pkg::MOVE_ID_W-1:0] move_id,
    output logic                             valid,
    output logic [1:0]                       rot,
    output logic [t01_ai_pkg::COL_W-1:0]     col
);
    import t01_ai_pkg::*;

    localparam logic [MOVE_ID_W-1:0] Step1 = MOVE_ID_W'(1 * NUM_COLS);
    localparam logic [MOVE_ID_W-1:0] Step2 = MOVE_ID_W'(2 * NUM_COLS);
    localparam logic [MOVE_ID_W-1:0] Step3 = MOVE_ID_W'(3 * NUM_COLS);
    localparam logic [MOVE_ID_W-1:0] Step4 = MOVE_ID_W'(NUM_ROTS * NUM_COLS);

    always_comb begin
        valid = 1'b1;
        rot   = 2'd0;
        col   = '0;
        if (move_id < Step1) begin
            col = COL_W'(move_id);
        end else if (move_id < Step2) begin
            rot = 2'd1;
            col = COL_W'(move_id - Step1);
        end else if (move_id < Step3) begin
            rot = 2'd2;
            col = COL_W'(move_id - Step2);
        end else if (move_id < Step4) begin
            rot = 2'd3;
            col = COL_W'(move_id - Step3);
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/t01_ai_move_sequencer.sv
// Converts one AI move ID into paced rotate/shift/drop pulses, shifting closed-loop on the
// live piece column and aborting when a new piece spawns or AI mode is switched off.
module t01_ai_move_sequencer #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MAX_TRIES  = 12,
    parameter int unsigned NUM_COLS   = t01_ai_pkg::NUM_COLS,
    parameter bit          AUTO_DROP  = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable_i,
    input  logic                             done_ai_i,
    input  logic [t01_ai_pkg::MOVE_ID_W-1:0] move_id_i,
    input  logic [t01_ai_pkg::COL_W-1:0]     piece_col_i,
    input  logic                             new_piece_i,
    output logic                             rotate_r_o,
    output logic                             left_o,
    output logic                             right_o,
    output logic                             drop_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o
);
    import t01_ai_pkg::*;

    localparam int unsigned     GapW     = $clog2(GAP_CYCLES + 1);
    localparam int unsigned     TryW     = $clog2(MAX_TRIES + 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [TryW-1:0] TryMax   = TryW'(MAX_TRIES);
    localparam seq_state_t      EndState = AUTO_DROP ? StDrop : StDone;

    seq_state_t       state_q, state_d;
    logic             done_ai_q;
    logic [1:0]       rot_q, rot_d;
    logic [COL_W-1:0] tgt_q, tgt_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [TryW-1:0]  try_q, try_d;
    logic             err_d;
    logic             rotate_d, left_d, right_d, drop_d, busy_d, done_d;

    logic             dec_valid;
    logic [1:0]       dec_rot;
    logic [COL_W-1:0] dec_col;

    logic start, abort, gap_done, at_target, tries_out, shift_move;

    t01_move_decode #(
        .NUM_COLS (NUM_COLS)
    ) u_decode (
        .move_id (move_id_i),
        .valid   (dec_valid),
        .rot     (dec_rot),
        .col     (dec_col)
    );

    assign start      = (state_q == StIdle) && enable_i && done_ai_i && !done_ai_q;
    assign abort      = (state_q != StIdle) && (new_piece_i || !enable_i);
    assign gap_done   = gap_q >= GapLast;
    assign at_target  = piece_col_i == tgt_q;
    assign tries_out  = try_q >= TryMax;
    assign shift_move = (state_q == StShift) && !at_target && !tries_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            done_ai_q  <= 1'b0;
            rot_q      <= '0;
            tgt_q      <= '0;
            gap_q      <= '0;
            try_q      <= '0;
            rotate_r_o <= 1'b0;
            left_o     <= 1'b0;
            right_o    <= 1'b0;
            drop_o     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_ai_q  <= done_ai_i;
            rot_q      <= rot_d;
            tgt_q      <= tgt_d;
            gap_q      <= gap_d;
            try_q      <= try_d;
            rotate_r_o <= rotate_d;
            left_o     <= left_d;
            right_o    <= right_d;
            drop_o     <= drop_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            err_o      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        tgt_d   = tgt_q;
        gap_d   = gap_q;
        try_d   = try_q;
        err_d   = err_o;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_d = StLatch;
                end
                StLatch: begin
                    if (!dec_valid) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        rot_d   = dec_rot;
                        tgt_d   = dec_col;
                        try_d   = '0;
                        state_d = (dec_rot != 2'd0) ? StRotate : StShift;
                    end
                end
                StRotate: begin
                    rot_d   = (rot_q != 2'd0) ? rot_q - 2'd1 : 2'd0;
                    gap_d   = '0;
                    state_d = StRotGap;
                end
                StRotGap: begin
                    if (gap_done) state_d = (rot_q != 2'd0) ? StRotate : StShift;
                    else          gap_d   = gap_q + 1'b1;
                end
                StShift: begin
                    if (at_target) begin
                        state_d = EndState;
                    end else if (tries_out) begin
                        err_d   = 1'b1;
                        state_d = EndState;
                    end else begin
                        try_d   = try_q + 1'b1;
                        gap_d   = '0;
                        state_d = StShiftGap;
                    end
                end
                StShiftGap: begin
                    if (gap_done) state_d = StShift;
                    else          gap_d   = gap_q + 1'b1;
                end
                StDrop:  state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Pulses are registered from the current state, so an abort in the same cycle kills them.
    always_comb begin
        rotate_d = !abort && (state_q == StRotate);
        left_d   = !abort && shift_move && (piece_col_i > tgt_q);
        right_d  = !abort && shift_move && (piece_col_i < tgt_q);
        drop_d   = !abort && (state_q == StDrop);
        done_d   = !abort && (state_q == StDone);
        busy_d   = !(state_d inside {StIdle, StDone});
    end

endmodule
